// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int          FETCH_WIDTH   = 32;
    localparam int          INSTR_BYTES   = 4;
    localparam logic [31:0] PC_ALIGN_MASK = ~32'(INSTR_BYTES - 1);

    // One prefetched instruction together with the address it came from.
    typedef struct packed {
        logic [FETCH_WIDTH-1:0] pc;
        logic [FETCH_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO of {pc, instr} entries with flush and count.
// The head is read from registered storage, so nothing combinational from the
// write side reaches the output. Empty queue presents an all-zero head.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  fetch_entry_t data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         valid_o,
    output logic         full_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Pointer/count next state; flush wins over any push or pop.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + PW'(1);
            if (pop_i)  rd_d = rd_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer/count registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents are don't-care while not counted, so no reset.
    always_ff @(posedge clk) begin
        if (rst && push_i && !flush_i) mem_q[wr_q] <= data_i;
    end

    assign valid_o = (cnt_q != '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign head_o  = valid_o ? mem_q[rd_q] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: program counter plus prefetch queue feeding decode.
// Handles decode back-pressure, redirect with flush, and halt.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          WIDTH    = FETCH_WIDTH,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    localparam int         CW       = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             halt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_instr,
    output logic [CW-1:0]    occupancy
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pop, push, full;
    fetch_entry_t     wr_entry, head;

    // Handshake: a pop alongside a redirect still counts as accepted by decode.
    always_comb begin
        pop  = out_valid & out_ready;
        push = ~halt & ~redirect & (~full | pop);
    end

    // PC next state: redirect target (word aligned), else advance on push.
    always_comb begin
        pc_d = pc_q;
        if (redirect)  pc_d = redirect_pc & PC_ALIGN_MASK;
        else if (push) pc_d = pc_q + WIDTH'(INSTR_BYTES);
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (!rst) pc_q <= RESET_PC;
        else      pc_q <= pc_d;
    end

    assign imem_addr = pc_q;
    assign wr_entry  = '{pc: pc_q, instr: imem_data};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (wr_entry),
        .pop_i   (pop),
        .flush_i (redirect),
        .head_o  (head),
        .valid_o (out_valid),
        .full_o  (full),
        .count_o (occupancy)
    );

    assign out_pc    = head.pc;
    assign out_instr = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, back-pressure, redirect,
// halt drain/resume, PC wrap and reset overriding redirect.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, redirect, halt, out_ready;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_data, out_pc, out_instr;
    logic        out_valid;
    logic [2:0]  occupancy;

    logic        redirect5, halt5, out_valid5;
    logic [31:0] redirect_pc5;
    logic [31:0] imem_addr5, imem_data5, out_pc5, out_instr5;
    logic [2:0]  occupancy5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_data  = 32'hA000_0000 | imem_addr;
    assign imem_data5 = 32'hA000_0000 | imem_addr5;

    fetch_unit #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .occupancy(occupancy)
    );

    fetch_unit #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut5 (
        .clk(clk), .rst(rst), .imem_addr(imem_addr5), .imem_data(imem_data5),
        .redirect(redirect5), .redirect_pc(redirect_pc5), .halt(halt5),
        .out_valid(out_valid5), .out_ready(out_ready), .out_pc(out_pc5),
        .out_instr(out_instr5), .occupancy(occupancy5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] occ);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".pc"}, out_pc, pc);
        chk({tag, ".instr"}, out_instr, v ? (32'hA000_0000 | pc) : 32'h0);
        chk({tag, ".occ"}, 32'(occupancy), occ);
    endtask

    initial begin
        rst = 1'b0; redirect = 1'b0; halt = 1'b0; out_ready = 1'b1;
        redirect_pc = 32'h0;
        redirect5 = 1'b0; halt5 = 1'b0; redirect_pc5 = 32'h0;
        tick(); tick();

        // Reset state
        chk_head("reset", 1'b0, 32'h0, 0);
        chk("reset.addr", imem_addr, 32'h0);
        chk("reset.addr5", imem_addr5, 32'hFFFF_FFF8);
        chk("reset.valid5", 32'(out_valid5), 32'h0);

        // Streaming with decode always ready: one entry per cycle, occupancy 1
        rst = 1'b1;
        tick();
        chk_head("stream0", 1'b1, 32'h0, 1);
        chk("stream0.addr", imem_addr, 32'h4);
        chk("wrap0", out_pc5, 32'hFFFF_FFF8);
        tick();
        chk_head("stream1", 1'b1, 32'h4, 1);
        chk("wrap1", out_pc5, 32'hFFFF_FFFC);
        tick();
        chk_head("stream2", 1'b1, 32'h8, 1);
        chk("wrap2", out_pc5, 32'h0000_0000);
        chk("wrap2.instr", out_instr5, 32'hA000_0000);
        tick();
        chk_head("stream3", 1'b1, 32'hC, 1);
        chk("stream3.addr", imem_addr, 32'h10);

        // Back-pressure: fills to 4 and pc stops advancing
        out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk_head($sformatf("bp%0d", i), 1'b1, 32'hC, (i < 3) ? 1 + i : 4);
            chk($sformatf("bp%0d.addr", i), imem_addr, 32'h10 + 4 * ((i < 3) ? i : 3));
        end

        // Release: full queue drains in order while refilling, occupancy stays 4
        out_ready = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            tick();
            chk_head($sformatf("drain%0d", j), 1'b1, 32'hC + 4 * j, 4);
        end
        chk("drain.addr", imem_addr, 32'h34);

        // Redirect from a full queue, unaligned target
        out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        chk_head("redir0", 1'b0, 32'h0, 0);
        chk("redir0.addr", imem_addr, 32'h100);
        redirect = 1'b0; out_ready = 1'b1;
        tick();
        chk_head("redir1", 1'b1, 32'h100, 1);
        chk("redir1.addr", imem_addr, 32'h104);

        // Build occupancy 3 then halt: three pops, then empty with pc held
        out_ready = 1'b0;
        tick(); tick();
        chk_head("pre_halt", 1'b1, 32'h100, 3);
        halt = 1'b1; out_ready = 1'b1;
        tick();
        chk_head("halt1", 1'b1, 32'h104, 2);
        tick();
        chk_head("halt2", 1'b1, 32'h108, 1);
        tick();
        chk_head("halt3", 1'b0, 32'h0, 0);
        tick();
        chk_head("halt4", 1'b0, 32'h0, 0);
        chk("halt4.addr", imem_addr, 32'h10C);
        halt = 1'b0;
        tick();
        chk_head("resume", 1'b1, 32'h10C, 1);
        chk("resume.addr", imem_addr, 32'h110);

        // Fill, then reset together with redirect: reset wins
        out_ready = 1'b0;
        tick(); tick(); tick();
        chk_head("fill", 1'b1, 32'h10C, 4);
        rst = 1'b0; redirect = 1'b1; redirect_pc = 32'h200; out_ready = 1'b1;
        tick();
        chk_head("rst_redir", 1'b0, 32'h0, 0);
        chk("rst_redir.addr", imem_addr, 32'h0);
        rst = 1'b1; redirect = 1'b0;
        tick();
        chk_head("post_rst", 1'b1, 32'h0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
